karatsuba_mult_axis: RTL and testbench
======================================

Name: karatsuba_mult_axis

Overview:
- Unsigned m x m -> 2m-bit multiplier using recursive Karatsuba decomposition, with AXI-Stream-style valid/data inputs X and Y and output Z.
- Fully pipelined: accepts one operand pair per clock and has a fixed 1-cycle latency.
- No backpressure (no tready).
- Used as the arithmetic core of the large-integer multiplier datapath; the FPGA self-test harness drives it every cycle.

Parameters:
- m, 328, operand width in bits (m >= 2).
- stage, 3, Karatsuba recursion depth; 0 = direct native multiply.

Ports:
- clk  in  1  single clock; all state on rising edge.
- aresetn  in  1  asynchronous active-low reset.
- X_tvalid  in  1  operand X valid.
- X_tdata  in  m  operand X, unsigned.
- Y_tvalid  in  1  operand Y valid.
- Y_tdata  in  m  operand Y, unsigned.
- Z_tvalid  out  1  product valid.
- Z_tdata  out  2m  product X*Y, unsigned.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (aresetn).
- Reset: while aresetn=0, Z_tvalid=0 and Z_tdata=0, asynchronously. The first capture happens on the first rising edge after deassertion.
- Datapath: combinational Karatsuba tree from X_tdata/Y_tdata into a single output register.
- Capture: on each rising edge, if X_tvalid&&Y_tvalid, then Z_tdata <= X_tdata*Y_tdata (exact, full 2m bits, no truncation) and Z_tvalid <= 1.
- Otherwise Z_tvalid <= 0 and Z_tdata holds its previous value.
- Latency: an operand pair present before edge k appears on Z after edge k. Throughput is 1 pair/cycle; back-to-back pairs produce back-to-back results.
- X and Y valids are not independently buffered. If only one of them is valid, that cycle is dropped.
- Karatsuba step for width w, depth d > 0:
  - h = ceil(w/2). Xl = X[h-1:0], Xh = X[w-1:h] (w-h bits), and the same split for Y.
  - P0 = Xl*Yl and P2 = Xh*Yh, each at width h, depth d-1 (Xh, Yh zero-extended).
  - Sx = Xl+Xh and Sy = Yl+Yh, each h+1 bits. P1 = Sx*Sy at width h+1, depth d-1.
  - Result = (P2 << 2h) + ((P1 - P2 - P0) << h) + P0, computed at 2w+2 bits and truncated to 2w.
  - The middle term is always non-negative.
- Depth 0, or w <= 4: plain unsigned w x w multiply.
- Odd widths and the resulting h+1 growth must be exact for every m >= 2 and every stage value, including stage deeper than log2(m).
- Boundaries:
  - All-ones operands: (2^m-1)^2 = 2^(2m) - 2^(m+1) + 1 exactly.
  - Zero operands give 0.
  - Reset asserted mid-stream clears Z_tvalid/Z_tdata immediately. The first post-reset result follows the normal 1-cycle latency.

Decomposition:
- Package karatsuba_pkg: function kara_half(w) = (w+1)/2; localparam KARA_BASE_WIDTH = 4.
- Sub-module karatsuba_core:
  - Parameters w and depth; inputs a, b (w bits); output p (2w bits); purely combinational.
  - Recursively instantiates three copies of itself via generate when depth > 0 and w > KARA_BASE_WIDTH, otherwise infers a multiply.
- The top level adds only the valid logic and the output register.

Test Plan:
- Reset: hold aresetn=0 with valid inputs -> Z_tvalid=0, Z_tdata=0. Deassert, drive X=3, Y=5 valid -> after the next edge Z_tvalid=1, Z=15.
- Streaming (m=328, stage=3): 16 pre-computed random pairs on consecutive cycles, both valids high -> each Z equals the reference product exactly one cycle later; 0 mismatches over 16 cycles, including wrap back to vector 0.
- Corners: X=Y=2^328-1 -> Z = 2^656 - 2^329 + 1. X=0, Y=2^328-1 -> 0. X=1, Y=0xABCD -> 0xABCD. X=2^327, Y=2 -> 2^328.
- Valid gating: X_tvalid=1 with Y_tvalid=0 -> Z_tvalid=0 next cycle and Z_tdata unchanged. Restore both valids -> correct product after 1 cycle.
- Parameter sweep: m in {2,3,7,17,64,328} x stage in {0,1,2,3,5} with random plus all-ones operands -> matches a behavioural reference product.
- Mid-stream reset: pulse aresetn low for 1 cycle during streaming -> outputs zero during reset; results resume with 1-cycle latency after release.

Source files
------------

// File: rtl/karatsuba_pkg.sv
// Shared constants and helpers for the Karatsuba multiplier.
//   KARA_BASE_WIDTH : at or below this operand width the recursion stops and a
//                     plain multiply is inferred.
//   kara_half(w)    : width of the low half of a w-bit operand, ceil(w/2).
package karatsuba_pkg;

   localparam int unsigned KARA_BASE_WIDTH = 4;

   function automatic int unsigned kara_half(input int unsigned w);
      return (w + 1) / 2;
   endfunction

endpackage

// File: rtl/karatsuba_core.sv
// Purely combinational unsigned w x w -> 2w multiplier built by recursive
// Karatsuba decomposition.
//   Parameters: w     - operand width
//               depth - remaining recursion depth (0 = direct multiply)
//   Ports:      a, b  - unsigned operands (w bits)
//               p     - exact product (2w bits)
module karatsuba_core
   import karatsuba_pkg::*;
#(
   parameter int unsigned w     = 8,
   parameter int unsigned depth = 1
) (
   input  logic [w-1:0]   a,
   input  logic [w-1:0]   b,
   output logic [2*w-1:0] p
);

   if (depth > 0 && w > KARA_BASE_WIDTH) begin : g_kara
      localparam int unsigned H = kara_half(w);

      logic [H-1:0]   w_xl, w_yl, w_xh, w_yh;
      logic [H:0]     w_sx, w_sy;
      logic [2*H-1:0] w_p0, w_p2;
      logic [2*H+1:0] w_p1;
      logic [2*w-1:0] w_p0e, w_p1e, w_p2e, w_mid;

      assign w_xl = a[H-1:0];
      assign w_yl = b[H-1:0];

      // High halves are w-H bits (one short of H for odd w); zero-extend to H.
      always_comb begin
         w_xh = '0;
         w_yh = '0;
         w_xh[w-H-1:0] = a[w-1:H];
         w_yh[w-H-1:0] = b[w-1:H];
      end

      assign w_sx = {1'b0, w_xl} + {1'b0, w_xh};
      assign w_sy = {1'b0, w_yl} + {1'b0, w_yh};

      karatsuba_core #(.w(H), .depth(depth - 1)) u_p0 (
         .a(w_xl), .b(w_yl), .p(w_p0)
      );
      karatsuba_core #(.w(H), .depth(depth - 1)) u_p2 (
         .a(w_xh), .b(w_yh), .p(w_p2)
      );
      karatsuba_core #(.w(H + 1), .depth(depth - 1)) u_p1 (
         .a(w_sx), .b(w_sy), .p(w_p1)
      );

      always_comb begin
         w_p0e = '0;
         w_p1e = '0;
         w_p2e = '0;
         w_p0e[2*H-1:0] = w_p0;
         w_p1e[2*H+1:0] = w_p1;
         w_p2e[2*H-1:0] = w_p2;
      end

      // Recombination is done modulo 2^(2w): the true product fits in 2w bits,
      // so any wrap in the intermediate terms cancels out exactly.
      assign w_mid = w_p1e - w_p2e - w_p0e;
      assign p     = (w_p2e << (2 * H)) + (w_mid << H) + w_p0e;
   end else begin : g_base
      assign p = {{w{1'b0}}, a} * {{w{1'b0}}, b};
   end

endmodule

// File: rtl/karatsuba_mult_axis.sv
// Unsigned m x m -> 2m multiplier with AXI-Stream style valid/data handshake.
// One operand pair per clock, fixed 1-cycle latency, no backpressure.
//   clk               - clock, rising edge
//   aresetn           - asynchronous active-low reset
//   X_tvalid/X_tdata  - operand X
//   Y_tvalid/Y_tdata  - operand Y
//   Z_tvalid/Z_tdata  - registered product; a cycle with only one operand
//                       valid is dropped and Z_tdata holds.
module karatsuba_mult_axis
   import karatsuba_pkg::*;
#(
   parameter int unsigned m     = 328,
   parameter int unsigned stage = 3
) (
   input  logic           clk,
   input  logic           aresetn,
   input  logic           X_tvalid,
   input  logic [m-1:0]   X_tdata,
   input  logic           Y_tvalid,
   input  logic [m-1:0]   Y_tdata,
   output logic           Z_tvalid,
   output logic [2*m-1:0] Z_tdata
);

   logic [2*m-1:0] w_prod;
   logic [2*m-1:0] r_z;
   logic           r_zv;

   karatsuba_core #(.w(m), .depth(stage)) u_core (
      .a(X_tdata),
      .b(Y_tdata),
      .p(w_prod)
   );

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         r_z  <= '0;
         r_zv <= 1'b0;
      end else if (X_tvalid && Y_tvalid) begin
         r_z  <= w_prod;
         r_zv <= 1'b1;
      end else begin
         r_zv <= 1'b0;
      end
   end

   assign Z_tdata  = r_z;
   assign Z_tvalid = r_zv;

endmodule

// File: tb/tb_karatsuba_mult_axis.sv
// Self-checking bench for karatsuba_mult_axis: directed vector table on the
// default configuration, hand-written reset/valid sequences, and a parameter
// sweep of independent instances.
module tb_karatsuba_mult_axis;

   localparam int unsigned M  = 328;
   localparam int unsigned ZW = 2 * M;

   logic          clk = 1'b0;
   logic          aresetn;
   logic          x_v, y_v;
   logic [M-1:0]  x_d, y_d;
   logic          z_v;
   logic [ZW-1:0] z_d;

   logic          sw_rstn;
   int            sw_done = 0;
   int            n_cmp   = 0;
   int            n_bad   = 0;

   always #5 clk = ~clk;

   karatsuba_mult_axis #(.m(M), .stage(3)) u_dut (
      .clk     (clk),
      .aresetn (aresetn),
      .X_tvalid(x_v),
      .X_tdata (x_d),
      .Y_tvalid(y_v),
      .Y_tdata (y_d),
      .Z_tvalid(z_v),
      .Z_tdata (z_d)
   );

   task automatic chk(input string nm, input logic [ZW-1:0] act, input logic [ZW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic int unsigned sweep_m(input int i);
      case (i)
         0: return 2;
         1: return 3;
         2: return 7;
         3: return 17;
         4: return 64;
         default: return 328;
      endcase
   endfunction

   function automatic int unsigned sweep_s(input int i);
      case (i)
         0: return 0;
         1: return 1;
         2: return 2;
         3: return 3;
         default: return 5;
      endcase
   endfunction

   // ---------------- parameter sweep ----------------
   for (genvar gi = 0; gi < 6; gi++) begin : g_m
      for (genvar gs = 0; gs < 5; gs++) begin : g_s
         localparam int unsigned SM = sweep_m(gi);
         localparam int unsigned SS = sweep_s(gs);

         logic            xv, yv, zv;
         logic [SM-1:0]   xd, yd;
         logic [2*SM-1:0] zd, ex;

         karatsuba_mult_axis #(.m(SM), .stage(SS)) u_sw (
            .clk     (clk),
            .aresetn (sw_rstn),
            .X_tvalid(xv),
            .X_tdata (xd),
            .Y_tvalid(yv),
            .Y_tdata (yd),
            .Z_tvalid(zv),
            .Z_tdata (zd)
         );

         initial begin
            xv = 1'b0;
            yv = 1'b0;
            xd = '0;
            yd = '0;
            wait (sw_rstn === 1'b1);
            for (int v = 0; v < 8; v++) begin
               if (v == 0) begin
                  xd = '1;
                  yd = '1;
               end else if (v == 1) begin
                  xd = '0;
                  yd = '1;
               end else begin
                  for (int k = 0; k < int'(SM); k++) begin
                     xd[k] = ($urandom() & 1) != 0;
                     yd[k] = ($urandom() & 1) != 0;
                  end
               end
               ex = {{SM{1'b0}}, xd} * {{SM{1'b0}}, yd};
               xv = 1'b1;
               yv = 1'b1;
               @(posedge clk);
               #1;
               chk($sformatf("sweep_m%0d_s%0d_v%0d_valid", SM, SS, v), ZW'(zv), ZW'(1'b1));
               chk($sformatf("sweep_m%0d_s%0d_v%0d_data", SM, SS, v), ZW'(zd), ZW'(ex));
            end
            xv = 1'b0;
            yv = 1'b0;
            sw_done++;
         end
      end
   end

   // ---------------- directed table ----------------
   typedef struct {
      logic [M-1:0]  x;
      logic [M-1:0]  y;
      logic [ZW-1:0] e;
   } vec_t;

   vec_t tab[16];

   initial begin
      logic [ZW-1:0] t;
      logic [ZW-1:0] prev;
      int            tmo;

      // corners with hand-derived products
      tab[0].x = '1;
      tab[0].y = '1;
      t = ZW'(1) << (M + 1);
      tab[0].e = ZW'(1) - t;                     // 2^656 - 2^329 + 1 (mod 2^656)
      tab[1].x = '0;
      tab[1].y = '1;
      tab[1].e = '0;
      tab[2].x = M'(1);
      tab[2].y = M'(16'hABCD);
      tab[2].e = ZW'(16'hABCD);
      tab[3].x = M'(1) << (M - 1);
      tab[3].y = M'(2);
      tab[3].e = ZW'(1) << M;
      tab[4].x = M'(3);
      tab[4].y = M'(5);
      tab[4].e = ZW'(15);
      tab[5].x = M'(32'hFFFF_FFFF);
      tab[5].y = M'(32'hFFFF_FFFF);
      tab[5].e = ZW'(64'hFFFF_FFFE_0000_0001);
      tab[6].x = M'(1) << 164;                   // top-level split point
      tab[6].y = (M'(1) << 164) - M'(1);
      tab[6].e = (ZW'(1) << 328) - (ZW'(1) << 164);
      for (int i = 7; i < 16; i++) begin
         for (int k = 0; k < int'(M); k++) begin
            tab[i].x[k] = ($urandom() & 1) != 0;
            tab[i].y[k] = ($urandom() & 1) != 0;
         end
         tab[i].e = {{M{1'b0}}, tab[i].x} * {{M{1'b0}}, tab[i].y};
      end

      // reset held with valid operands
      aresetn = 1'b0;
      sw_rstn = 1'b0;
      x_v = 1'b1;
      y_v = 1'b1;
      x_d = M'(3);
      y_d = M'(5);
      repeat (2) @(posedge clk);
      #1;
      chk("reset_valid", ZW'(z_v), '0);
      chk("reset_data", z_d, '0);

      sw_rstn = 1'b1;
      aresetn = 1'b1;
      @(posedge clk);
      #1;
      chk("first_valid", ZW'(z_v), ZW'(1'b1));
      chk("first_data", z_d, ZW'(15));

      // back-to-back streaming, wrapping back to vector 0
      for (int i = 0; i < 17; i++) begin
         x_d = tab[i % 16].x;
         y_d = tab[i % 16].y;
         @(posedge clk);
         #1;
         chk($sformatf("stream%0d_valid", i), ZW'(z_v), ZW'(1'b1));
         chk($sformatf("stream%0d_data", i), z_d, tab[i % 16].e);
      end

      // only one operand valid: cycle dropped, data held
      prev = tab[0].e;
      x_d  = tab[5].x;
      y_d  = tab[5].y;
      y_v  = 1'b0;
      @(posedge clk);
      #1;
      chk("xonly_valid", ZW'(z_v), '0);
      chk("xonly_hold", z_d, prev);
      x_v = 1'b0;
      y_v = 1'b1;
      @(posedge clk);
      #1;
      chk("yonly_valid", ZW'(z_v), '0);
      chk("yonly_hold", z_d, prev);
      x_v = 1'b1;
      x_d = tab[6].x;
      y_d = tab[6].y;
      @(posedge clk);
      #1;
      chk("restore_valid", ZW'(z_v), ZW'(1'b1));
      chk("restore_data", z_d, tab[6].e);

      // reset pulse in the middle of a stream
      x_d = tab[7].x;
      y_d = tab[7].y;
      @(posedge clk);
      #1;
      chk("pre_rst_data", z_d, tab[7].e);
      x_d = tab[8].x;
      y_d = tab[8].y;
      aresetn = 1'b0;
      #1;
      chk("midrst_async_valid", ZW'(z_v), '0);
      chk("midrst_async_data", z_d, '0);
      @(posedge clk);
      #1;
      chk("midrst_edge_valid", ZW'(z_v), '0);
      chk("midrst_edge_data", z_d, '0);
      aresetn = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_valid", ZW'(z_v), ZW'(1'b1));
      chk("post_rst_data", z_d, tab[8].e);
      x_d = tab[9].x;
      y_d = tab[9].y;
      @(posedge clk);
      #1;
      chk("post_rst_next", z_d, tab[9].e);
      x_v = 1'b0;
      y_v = 1'b0;

      tmo = 0;
      while (sw_done < 30 && tmo < 200) begin
         @(posedge clk);
         tmo++;
      end
      chk("sweep_done", ZW'(sw_done), ZW'(30));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
